// File: rtl/gppcu_cmd_master.sv
// Host-side initiator for the GPPCU test-queue command port: buffers requests,
// drives a timed opclk pulse per request and returns read-back data.
// Build option: GPPCU_CMD_MASTER_WAITDONE_EN adds the wparam=127 wait-for-iDONE request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a FIFO entry; pops it and latches the fields
// SETUP    | fields driven, opclk low, SETUP_CYC cycles
// HIGH     | opclk high, HIGH_CYC cycles
// HOLD     | opclk low, fields held, HOLD_CYC cycles; last cycle samples iDATA
// RESP     | response presented until iRSP_READY
// WAITDONE | (option only) waiting for iDONE, no opclk pulse
module gppcu_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int HIGH_CYC   = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic        iACLK,
  input  logic        inRST,
  input  logic        iREQ_VALID,
  output logic        oREQ_READY,
  input  logic [6:0]  iREQ_WPARAM,
  input  logic [7:0]  iREQ_LPARAM,
  input  logic [15:0] iREQ_COMMAND,
  input  logic [31:0] iREQ_DATA,
  output logic [31:0] oCMD,
  output logic [31:0] oDATA,
  input  logic [31:0] iDATA,
  input  logic        iDONE,
  output logic        oRSP_VALID,
  input  logic        iRSP_READY,
  output logic [31:0] oRSP_DATA,
  output logic [6:0]  oRSP_WPARAM,
  output logic        oBUSY
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((HIGH_CYC > HOLD_CYC) ? HIGH_CYC : HOLD_CYC);
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [6:0] WP_READ = 7'd1;
  localparam logic [6:0] WP_CMD  = 7'd4;
`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
  localparam logic [6:0] WP_WAIT = 7'd127;
`endif

  typedef struct packed {
    logic [6:0]  wparam;
    logic [7:0]  lparam;
    logic [15:0] command;
    logic [31:0] data;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_HIGH, ST_HOLD, ST_RESP
`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
    , ST_WAITDONE
`endif
  } state_t;

  req_t          fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty, push, pop;
  req_t          head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [30:0]   cmd_q;
  logic          rsp_type, cap_hold, cap_wait;

  // Full when pointers differ only in the wrap bit.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign oREQ_READY = ~fifo_full;
  assign push       = iREQ_VALID & ~fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign rsp_type   = (cmd_q[30:24] == WP_READ) || (cmd_q[30:24] == WP_CMD);

  always_ff @(posedge iACLK) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {iREQ_WPARAM, iREQ_LPARAM, iREQ_COMMAND, iREQ_DATA};
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase counter counts down and reloads on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
          if (head.wparam == WP_WAIT) begin
            state_d = ST_WAITDONE;
            cnt_d   = '0;
          end
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(HIGH_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = rsp_type ? ST_RESP : ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (iRSP_READY) state_d = ST_IDLE;
      end
`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
      ST_WAITDONE: begin
        if (iDONE) state_d = ST_RESP;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // opclk and response-valid decode straight from state so reset drops them at once.
  always_comb begin
    oCMD       = {state_q == ST_HIGH, cmd_q};
    oRSP_VALID = (state_q == ST_RESP);
    oBUSY      = ~fifo_empty | (state_q != ST_IDLE);
    cap_hold   = (state_q == ST_HOLD) && (cnt_q == '0);
    cap_wait   = 1'b0;
`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
    cap_wait   = (state_q == ST_WAITDONE) && iDONE;
`endif
  end

`ifndef GPPCU_CMD_MASTER_WAITDONE_EN
  logic done_unused;
  assign done_unused = iDONE;
`endif

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      cmd_q       <= '0;
      oDATA       <= '0;
      oRSP_DATA   <= '0;
      oRSP_WPARAM <= '0;
    end else begin
      if (pop) begin
        cmd_q <= {head.wparam, head.lparam, head.command};
        oDATA <= head.data;
      end
      if (cap_hold) begin
        oRSP_DATA   <= iDATA;
        oRSP_WPARAM <= cmd_q[30:24];
      end else if (cap_wait) begin
        oRSP_DATA   <= '0;
        oRSP_WPARAM <= 7'd127;
      end
    end
  end

endmodule

// File: tb/tb_gppcu_cmd_master.sv
// Directed bench for gppcu_cmd_master with default timing parameters
// (SETUP/HIGH/HOLD = 2 cycles, FIFO depth 4).
module tb_gppcu_cmd_master;
  logic        iACLK = 1'b0;
  logic        inRST;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic [6:0]  iREQ_WPARAM;
  logic [7:0]  iREQ_LPARAM;
  logic [15:0] iREQ_COMMAND;
  logic [31:0] iREQ_DATA;
  logic [31:0] oCMD;
  logic [31:0] oDATA;
  logic [31:0] iDATA;
  logic        iDONE;
  logic        oRSP_VALID;
  logic        iRSP_READY;
  logic [31:0] oRSP_DATA;
  logic [6:0]  oRSP_WPARAM;
  logic        oBUSY;

  int checks = 0;
  int errors = 0;

  gppcu_cmd_master dut (
    .iACLK(iACLK), .inRST(inRST),
    .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
    .iREQ_WPARAM(iREQ_WPARAM), .iREQ_LPARAM(iREQ_LPARAM),
    .iREQ_COMMAND(iREQ_COMMAND), .iREQ_DATA(iREQ_DATA),
    .oCMD(oCMD), .oDATA(oDATA), .iDATA(iDATA), .iDONE(iDONE),
    .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY),
    .oRSP_DATA(oRSP_DATA), .oRSP_WPARAM(oRSP_WPARAM), .oBUSY(oBUSY)
  );

  always #5 iACLK = ~iACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iACLK);
    #1;
  endtask

  task automatic push(input logic [6:0] wp, input logic [7:0] lp,
                      input logic [15:0] cmd, input logic [31:0] dat);
    int n = 0;
    iREQ_VALID = 1'b1; iREQ_WPARAM = wp; iREQ_LPARAM = lp;
    iREQ_COMMAND = cmd; iREQ_DATA = dat;
    while (!oREQ_READY && n < 200) begin tick(); n++; end
    if (n >= 200) check("push_timeout", 32'(n), 32'd0);
    tick();
    iREQ_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oBUSY && n < 200) begin tick(); n++; end
    check(tag, 32'(oBUSY), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!oRSP_VALID && n < 200) begin tick(); n++; end
    check(tag, 32'(oRSP_VALID), 32'd1);
  endtask

  task automatic wait_opclk(input string tag);
    int n = 0;
    while (!oCMD[31] && n < 200) begin tick(); n++; end
    check(tag, 32'(oCMD[31]), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_wr [6];
    logic        prev;
    logic        acc;
    int          k, cnt, rises;

    inRST = 1'b1; iREQ_VALID = 1'b0; iREQ_WPARAM = '0; iREQ_LPARAM = '0;
    iREQ_COMMAND = '0; iREQ_DATA = '0; iDATA = '0; iDONE = 1'b0; iRSP_READY = 1'b1;
    #2 inRST = 1'b0;
    #1;
    check("rst_cmd", oCMD, 32'h0);
    check("rst_data", oDATA, 32'h0);
    check("rst_rsp_valid", 32'(oRSP_VALID), 32'd0);
    check("rst_rsp_data", oRSP_DATA, 32'h0);
    check("rst_rsp_wp", 32'(oRSP_WPARAM), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_ready", 32'(oREQ_READY), 32'd1);
    tick(); tick();
    inRST = 1'b1;
    tick();

    // Write local: 2 setup, 2 high, 2 hold cycles.
    exp_wr = '{32'h02010005, 32'h02010005, 32'h82010005, 32'h82010005, 32'h02010005, 32'h02010005};
    push(7'd2, 8'd1, 16'h0005, 32'hA5A50001);
    check("wr_busy", 32'(oBUSY), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("wr_cmd%0d", i), oCMD, exp_wr[i]);
      check($sformatf("wr_data%0d", i), oDATA, 32'hA5A50001);
      check($sformatf("wr_norsp%0d", i), 32'(oRSP_VALID), 32'd0);
    end
    tick();
    check("wr_busy_end", 32'(oBUSY), 32'd0);
    check("wr_norsp_end", 32'(oRSP_VALID), 32'd0);

    // Read local: response appears the cycle after the last HOLD cycle.
    push(7'd1, 8'd0, 16'h0003, 32'h0);
    tick(); tick(); tick();
    check("rd_opclk_rise", oCMD, 32'h81000003);
    iDATA = 32'h00000012;
    tick(); tick(); tick();
    check("rd_hold_norsp", 32'(oRSP_VALID), 32'd0);
    tick();
    check("rd_rsp_valid", 32'(oRSP_VALID), 32'd1);
    check("rd_rsp_data", oRSP_DATA, 32'h00000012);
    check("rd_rsp_wp", 32'(oRSP_WPARAM), 32'd1);
    tick();
    check("rd_rsp_done", 32'(oRSP_VALID), 32'd0);
    check("rd_idle", 32'(oBUSY), 32'd0);

    // FIFO full: one read parked in RESP, four writes fill the FIFO.
    iRSP_READY = 1'b0;
    push(7'd1, 8'd0, 16'h0010, 32'h0);
    for (int i = 0; i < 4; i++) push(7'd2, 8'd0, 16'h0101 + 16'(i), 32'h0);
    check("full_ready_low", 32'(oREQ_READY), 32'd0);
    iREQ_VALID = 1'b1; iREQ_WPARAM = 7'd2; iREQ_LPARAM = 8'd0;
    iREQ_COMMAND = 16'h0105; iREQ_DATA = 32'h0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (oREQ_READY) cnt++;
      tick();
    end
    check("full_ready_stays_low", 32'(cnt), 32'd0);
    check("full_rsp_valid", 32'(oRSP_VALID), 32'd1);
    check("full_rsp_wp", 32'(oRSP_WPARAM), 32'd1);
    iRSP_READY = 1'b1;
    k = 0;
    prev = oCMD[31];
    for (int c = 0; c < 200 && k < 5; c++) begin
      acc = iREQ_VALID & oREQ_READY;
      tick();
      if (acc) iREQ_VALID = 1'b0;
      if (oCMD[31] && !prev) begin
        check($sformatf("order%0d", k), oCMD, 32'h82000101 + 32'(k));
        k++;
      end
      prev = oCMD[31];
    end
    check("order_count", 32'(k), 32'd5);
    wait_idle("full_idle");

    // Response stall: second read must not pulse until the first is taken.
    iDATA = 32'h55; iRSP_READY = 1'b0;
    push(7'd1, 8'd0, 16'h0020, 32'h0);
    push(7'd1, 8'd0, 16'h0021, 32'h0);
    wait_rsp("stall_rsp1");
    iDATA = 32'h66;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!oRSP_VALID || oRSP_DATA !== 32'h55 || oRSP_WPARAM !== 7'd1 || oCMD !== 32'h01000020) cnt++;
    end
    check("stall_stable", 32'(cnt), 32'd0);
    iRSP_READY = 1'b1;
    wait_opclk("stall_opclk2");
    check("stall_cmd2", oCMD, 32'h81000021);
    wait_rsp("stall_rsp2");
    check("stall_rsp2_data", oRSP_DATA, 32'h66);
    wait_idle("stall_idle");

    // Reset mid-HIGH: queued entries are discarded.
    push(7'd2, 8'd0, 16'h0030, 32'h0);
    push(7'd2, 8'd0, 16'h0031, 32'h0);
    push(7'd2, 8'd0, 16'h0032, 32'h0);
    wait_opclk("rst_mid_opclk");
    #2 inRST = 1'b0;
    #1;
    check("rst_mid_cmd", oCMD, 32'h0);
    check("rst_mid_rsp", 32'(oRSP_VALID), 32'd0);
    tick(); tick();
    inRST = 1'b1;
    check("rst_mid_ready", 32'(oREQ_READY), 32'd1);
    check("rst_mid_busy", 32'(oBUSY), 32'd0);
    rises = 0; prev = oCMD[31];
    for (int i = 0; i < 30; i++) begin
      tick();
      if (oCMD[31] && !prev) rises++;
      prev = oCMD[31];
    end
    check("rst_mid_no_issue", 32'(rises), 32'd0);
    check("rst_mid_cmd_after", oCMD, 32'h0);

`ifdef GPPCU_CMD_MASTER_WAITDONE_EN
    // Wait request: no pulse, response after iDONE.
    push(7'd127, 8'd0, 16'h0040, 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oCMD[31] || oRSP_VALID) cnt++;
    end
    check("wait_no_pulse", 32'(cnt), 32'd0);
    check("wait_busy", 32'(oBUSY), 32'd1);
    iDONE = 1'b1;
    tick();
    iDONE = 1'b0;
    check("wait_rsp_valid", 32'(oRSP_VALID), 32'd1);
    check("wait_rsp_wp", 32'(oRSP_WPARAM), 32'd127);
    check("wait_rsp_data", oRSP_DATA, 32'h0);
    wait_idle("wait_idle");
`else
    // wparam 127 without the option behaves as a write.
    push(7'd127, 8'd0, 16'h0040, 32'h0);
    wait_opclk("wp127_opclk");
    check("wp127_cmd", oCMD, 32'hFF000040);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oRSP_VALID) cnt++;
    end
    check("wp127_norsp", 32'(cnt), 32'd0);
    wait_idle("wp127_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
